// File: rtl/cf_tmr_pwm_pkg.sv
// Shared constants for the cf_tmr_pwm multi-channel timer/PWM core.
// Direction encodings, default sizes and the counter FSM state type.
package cf_tmr_pwm_pkg;
   localparam int DEF_WIDTH = 32;
   localparam int DEF_NCH   = 4;
   localparam int DEF_PSC_W = 8;

   localparam logic [1:0] DIR_UP     = 2'b00;
   localparam logic [1:0] DIR_DOWN   = 2'b01;
   localparam logic [1:0] DIR_UPDOWN = 2'b10;
   localparam logic [1:0] DIR_HOLD   = 2'b11;

   typedef enum logic [1:0] {IDLE, RUN_UP, RUN_DOWN} state_t;
endpackage

// File: rtl/cf_tmr_pwm_ch.sv
// One PWM channel: compare (optionally shadowed), polarity/fault gating, pwm and match registers.
// CF_TMR_PWM_SHADOW_EN adds the compare shadow register and its load port.
module cf_tmr_pwm_ch #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef CF_TMR_PWM_SHADOW_EN
   input  logic             load,
`endif
   input  logic [WIDTH-1:0] cmp,
   input  logic             pol,
   input  logic [WIDTH-1:0] cnt_nxt,
   input  logic             adv,
   input  logic             force_off,
   output logic             pwm,
   output logic             match
);
   logic [WIDTH-1:0] cmp_nxt;

`ifdef CF_TMR_PWM_SHADOW_EN
   logic [WIDTH-1:0] cmp_q;

   // Compare against the value that will be active after this edge.
   assign cmp_nxt = load ? cmp : cmp_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cmp_q <= '0;
      else        cmp_q <= cmp_nxt;
   end
`else
   assign cmp_nxt = cmp;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm   <= 1'b0;
         match <= 1'b0;
      end else begin
         pwm   <= force_off ? pol : ((cnt_nxt < cmp_nxt) ^ pol);
         match <= adv & (cnt_nxt == cmp_nxt);
      end
   end
endmodule

// File: rtl/cf_tmr_pwm_mc.sv
// Multi-channel timer/PWM core: prescaler, up/down/up-down counter FSM, fault sync and flag.
// Define CF_TMR_PWM_SHADOW_EN to double-buffer period and compare values.
module cf_tmr_pwm_mc
   import cf_tmr_pwm_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NCH   = DEF_NCH,
   parameter int PSC_W = DEF_PSC_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [1:0]           dir,
   input  logic                 oneshot,
   input  logic                 restart,
   input  logic [PSC_W-1:0]     prescale,
   input  logic [WIDTH-1:0]     period,
   input  logic [NCH*WIDTH-1:0] cmp,
   input  logic [NCH-1:0]       pol,
   input  logic                 pwm_fault,
   input  logic                 fault_clr,
   output logic [NCH-1:0]       pwm,
   output logic [WIDTH-1:0]     count,
   output logic                 timeout_flag,
   output logic [NCH-1:0]       match,
   output logic                 fault_flag
);
   localparam logic [WIDTH-1:0] CNT_ONE = 1;
   localparam logic [PSC_W-1:0] PSC_ONE = 1;

   state_t           state, state_nxt;
   logic [PSC_W-1:0] psc_cnt;
   logic [WIDTH-1:0] cnt_nxt, period_act;
   logic             running, tick, tmo_nxt, adv;
   logic             flt_m, flt_s, fault_nxt;

   assign running = (state != IDLE);
   assign tick    = en & running & (psc_cnt == prescale);
   assign adv     = tick & ~restart;

`ifdef CF_TMR_PWM_SHADOW_EN
   logic             load;
   logic [WIDTH-1:0] period_q;

   assign load       = restart | tmo_nxt | ~running;
   assign period_act = period_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    period_q <= '0;
      else if (load) period_q <= period;
   end
`else
   assign period_act = period;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                psc_cnt <= '0;
      else if (restart || tick)  psc_cnt <= '0;
      else if (en && running)    psc_cnt <= psc_cnt + PSC_ONE;
   end

   // Down reloads use the period input: in shadow mode it is loaded on the same edge.
   always_comb begin
      cnt_nxt   = count;
      state_nxt = state;
      tmo_nxt   = 1'b0;
      if (restart) begin
         cnt_nxt   = (dir == DIR_DOWN) ? period : '0;
         state_nxt = RUN_UP;
      end else if (tick) begin
         if (period_act == '0) begin
            cnt_nxt = '0;
            tmo_nxt = 1'b1;
         end else begin
            case (dir)
               DIR_UP: begin
                  if (count == period_act) begin
                     cnt_nxt = '0;
                     tmo_nxt = 1'b1;
                  end else cnt_nxt = count + CNT_ONE;
               end
               DIR_DOWN: begin
                  if (count == '0) begin
                     cnt_nxt = period;
                     tmo_nxt = 1'b1;
                  end else cnt_nxt = count - CNT_ONE;
               end
               DIR_UPDOWN: begin
                  if (state == RUN_DOWN) begin
                     cnt_nxt = (count == '0) ? count + CNT_ONE : count - CNT_ONE;
                     if (count == '0) begin
                        state_nxt = RUN_UP;
                        tmo_nxt   = 1'b1;
                     end
                  end else if (count == period_act) begin
                     cnt_nxt   = count - CNT_ONE;
                     state_nxt = RUN_DOWN;
                  end else cnt_nxt = count + CNT_ONE;
               end
               default: ;
            endcase
         end
         if (tmo_nxt && oneshot) state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         count        <= '0;
         timeout_flag <= 1'b0;
      end else begin
         state        <= state_nxt;
         count        <= cnt_nxt;
         timeout_flag <= tmo_nxt;
      end
   end

   // Channels gate on the next flag value so a fault forces pwm on the flag's own edge.
   assign fault_nxt = flt_s | (fault_flag & ~fault_clr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flt_m      <= 1'b0;
         flt_s      <= 1'b0;
         fault_flag <= 1'b0;
      end else begin
         flt_m      <= pwm_fault;
         flt_s      <= flt_m;
         fault_flag <= fault_nxt;
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      cf_tmr_pwm_ch #(.WIDTH(WIDTH)) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
`ifdef CF_TMR_PWM_SHADOW_EN
         .load      (load),
`endif
         .cmp       (cmp[i*WIDTH +: WIDTH]),
         .pol       (pol[i]),
         .cnt_nxt   (cnt_nxt),
         .adv       (adv),
         .force_off (fault_nxt),
         .pwm       (pwm[i]),
         .match     (match[i])
      );
   end
endmodule
